// File: rtl/j1_io_timer.sv
// J1 IO-mapped down-counting timer with prescaler, sticky status and one-shot interrupt.
// Optional J1_TIMER_CAPTURE_EN adds a 32-bit free-running cycle counter with split-read capture.
module j1_io_timer #(
  parameter logic [15:0] BASE     = 16'h4000,
  parameter logic [15:0] ID_VALUE = 16'h4A31
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        io_rd,
  input  logic        io_wr,
  input  logic [15:0] io_addr,
  input  logic [15:0] io_dout,
  output logic [15:0] io_din,
  output logic        int_req
);

  logic        en, reload, ien;
  logic [15:0] load_r, count_r, presc_r, psc;
  logic        pend, ovf;
  logic        pend_nxt, ovf_nxt;
  logic [15:0] cap_lo, cap_hi;

  logic       sel;
  logic [2:0] idx;
  logic       wr_ctrl, wr_load, wr_count, wr_status, wr_presc;
  logic       tick, expire;

  assign sel       = (io_addr[15:4] == BASE[15:4]);
  assign idx       = io_addr[3:1];
  assign wr_ctrl   = io_wr & sel & (idx == 3'd0);
  assign wr_load   = io_wr & sel & (idx == 3'd1);
  assign wr_count  = io_wr & sel & (idx == 3'd2);
  assign wr_status = io_wr & sel & (idx == 3'd3);
  assign wr_presc  = io_wr & sel & (idx == 3'd4);

  assign tick   = en & (psc == presc_r);
  // A software COUNT write suppresses both the decrement and the expiry.
  assign expire = tick & (count_r == '0) & ~wr_count;

  // Expiry wins over a same-cycle write-1-to-clear.
  assign pend_nxt = expire | (pend & ~(wr_status & io_dout[0]));
  assign ovf_nxt  = (expire & pend) | (ovf & ~(wr_status & io_dout[1]));

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      en      <= 1'b0;
      reload  <= 1'b0;
      ien     <= 1'b0;
      load_r  <= '0;
      count_r <= '0;
      presc_r <= '0;
      psc     <= '0;
      pend    <= 1'b0;
      ovf     <= 1'b0;
      int_req <= 1'b0;
    end else begin
      if (wr_ctrl || wr_count || wr_presc || tick)
        psc <= '0;
      else if (en)
        psc <= psc + 16'd1;

      if (wr_ctrl)
        {ien, reload, en} <= io_dout[2:0];
      else if (expire && !reload)
        en <= 1'b0;

      if (wr_load)
        load_r <= io_dout;
      if (wr_presc)
        presc_r <= io_dout;

      if (wr_count)
        count_r <= io_dout;
      else if (tick) begin
        if (count_r != '0)
          count_r <= count_r - 16'd1;
        else if (reload)
          count_r <= load_r;
      end

      pend    <= pend_nxt;
      ovf     <= ovf_nxt;
      int_req <= pend_nxt & ~pend & ien;
    end
  end

`ifdef J1_TIMER_CAPTURE_EN
  logic [31:0] cyc_cnt;
  logic [15:0] caph;

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      cyc_cnt <= '0;
      caph    <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (io_rd && !io_wr && sel && (idx == 3'd6))
        caph <= cyc_cnt[31:16];
    end
  end

  assign cap_lo = cyc_cnt[15:0];
  assign cap_hi = caph;
`else
  assign cap_lo = '0;
  assign cap_hi = '0;
`endif

  logic unused_ok;
  assign unused_ok = ^{io_addr[0], io_rd};

  always_comb begin
    io_din = '0;
    if (sel) begin
      case (idx)
        3'd0:    io_din = {13'd0, ien, reload, en};
        3'd1:    io_din = load_r;
        3'd2:    io_din = count_r;
        3'd3:    io_din = {14'd0, ovf, pend};
        3'd4:    io_din = presc_r;
        3'd5:    io_din = ID_VALUE;
        3'd6:    io_din = cap_lo;
        default: io_din = cap_hi;
      endcase
    end
  end

endmodule

// File: doc/j1_io_timer.md
J1_IO_TIMER -- requirements
Module: j1_io_timer

Interface
REQ-001 SHALL have parameter BASE, 16'h4000, IO byte address of register 0; bits [3:0] are ignored.
REQ-002 SHALL have parameter ID_VALUE, 16'h4A31, constant returned by the ID register.
REQ-003 SHALL have port sys_clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port sys_rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port io_rd  input  1  CPU IO read strobe; the read data is consumed in the same cycle.
REQ-006 SHALL have port io_wr  input  1  CPU IO write strobe; the write commits at the rising edge.
REQ-007 SHALL have port io_addr  input  16  byte address from the CPU T register.
REQ-008 SHALL have port io_dout  input  16  write data from the CPU N register.
REQ-009 SHALL have port io_din  output  16  read data to the CPU.
REQ-010 SHALL have port int_req  output  1  interrupt request to the CPU, one-cycle pulse.

Function
REQ-011 SHALL select the block when io_addr[15:4]==BASE[15:4]; the register index is io_addr[3:1]; io_addr[0] is ignored.
REQ-012 SHALL drive io_din combinationally from io_addr: selected register value when selected, otherwise 16'h0000; zero latency, and io_rd is not required to gate it.
REQ-013 SHALL implement this register map:
- 0x0 CTRL: R/W; bit0 EN, bit1 RELOAD, bit2 IEN; other bits read 0.
- 0x2 LOAD: R/W.
- 0x4 COUNT: R/W.
- 0x6 STATUS: bit0 PEND, bit1 OVF; write 1 to clear.
- 0x8 PRESC: R/W.
- 0xA ID: read-only, ID_VALUE.
- 0xC, 0xE: per REQ-026/027.
REQ-014 SHALL ignore writes to ID and to unselected addresses; io_wr and io_rd both high in the same cycle is a write and causes no read side effect.
REQ-015 SHALL run a 16-bit prescaler only while EN=1: it counts 0..PRESC, then emits a one-cycle tick and returns to 0; PRESC=0 produces a tick every cycle.
REQ-016 SHALL handle each tick as follows:
- COUNT!=0: COUNT decrements by 1.
- COUNT==0: expiry event.
REQ-017 SHALL, on expiry: set PEND; set OVF if PEND was already 1; if RELOAD=1 load COUNT<=LOAD, else clear EN and leave COUNT at 0.
REQ-018 SHALL give an expiry period of (LOAD+1)*(PRESC+1) cycles when RELOAD=1.
REQ-019 SHALL clear the prescaler to 0 on any write to COUNT, PRESC or CTRL.
REQ-020 SHALL give a software write to COUNT priority over a same-cycle tick (written value taken, no decrement, no expiry).
REQ-021 SHALL give a same-cycle expiry priority over a STATUS write-1-to-clear: the bit ends set.
REQ-022 SHALL assert int_req for exactly one cycle, in the cycle after PEND goes 0->1, and only when IEN=1 at that edge.
REQ-023 SHALL NOT generate an int_req pulse on expiry while PEND is already 1, nor on setting IEN while PEND=1.
REQ-024 SHALL register int_req (flop output, no combinational path from inputs).

Reset
REQ-025 SHALL, while sys_rst_i=1 at an edge, set:
- CTRL=0, LOAD=0, COUNT=0, PRESC=0, PEND=0, OVF=0;
- prescaler=0, int_req=0, capture state=0.
Reset mid-count aborts the count immediately and drops any pending int_req. io_din stays a combinational decode of register state during reset.

Configuration
REQ-026 SHALL, with J1_TIMER_CAPTURE_EN defined, implement a 32-bit free-running cycle counter, not gated by EN, and the following reads:
- Offset 0xC returns counter[15:0].
- An io_rd at 0xC latches counter[31:16] into CAPH at that edge.
- Offset 0xE returns CAPH.
- Writes to 0xC/0xE are ignored.
REQ-027 SHALL, without J1_TIMER_CAPTURE_EN, omit the cycle counter and CAPH logic, and read 0xC/0xE as 16'h0000.

Verification
REQ-028 SHALL cover: reset, then read 0xA -> io_din=16'h4A31 in the same cycle; read 0x0 -> 16'h0000; int_req=0.
REQ-029 SHALL cover: LOAD=3, PRESC=1, COUNT=3, CTRL=7 -> expiry 8 cycles after the CTRL write edge, PEND=1, one int_req pulse, COUNT reloads to 3, next expiry 8 cycles later with OVF=1 and no second pulse.
REQ-030 SHALL cover: CTRL=1 (no RELOAD, no IEN), COUNT=2, PRESC=0 -> expiry at the third tick, EN reads 0, COUNT stays 0, PEND=1, int_req never asserted.
REQ-031 SHALL cover: write STATUS=16'h0001 in the same cycle as an expiry -> PEND remains 1; write COUNT=16'h0010 in a tick cycle -> COUNT reads 16'h0010.
REQ-032 SHALL cover: sys_rst_i pulsed one cycle with COUNT=5, EN=1, in the cycle an expiry would occur -> all registers 0, no int_req.
REQ-033 SHALL cover, with J1_TIMER_CAPTURE_EN: 70000 cycles after reset, read 0xC then 0xE -> the 0xE value equals the upper half as sampled at the 0xC read; without the macro both reads return 16'h0000.
